// File: rtl/fcb_arb_pkg.sv
// ----------------------------------------------------------------------------
// fcb_arb_pkg : shared state encoding, requester ids and defaults for the FCB APB arbiter
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package fcb_arb_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETUP  = 2'd1;
  localparam logic [1:0] ST_ACCESS = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  localparam logic REQ_JTAG = 1'b0;
  localparam logic REQ_HOST = 1'b1;

  localparam int unsigned TIMEOUT_CYC_DEF = 256;

  function automatic logic [1:0] id_onehot(input logic id);
    return (id == REQ_HOST) ? 2'b10 : 2'b01;
  endfunction

endpackage

`default_nettype wire

// File: rtl/fcb_arb_rr2.sv
// ----------------------------------------------------------------------------
// fcb_arb_rr2 : combinational 2-way round-robin pick with lock qualifier
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module fcb_arb_rr2
  import fcb_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  input  logic       lock,
  input  logic       lock_id,
  output logic       gnt_valid,
  output logic       gnt_id
);

  always_comb begin
    gnt_valid = 1'b0;
    gnt_id    = REQ_JTAG;
    if (lock) begin
      // A held lock excludes the other requester entirely.
      gnt_valid = req[lock_id];
      gnt_id    = lock_id;
    end else if (req == 2'b11) begin
      gnt_valid = 1'b1;
      gnt_id    = ~last;
    end else if (req[0]) begin
      gnt_valid = 1'b1;
      gnt_id    = REQ_JTAG;
    end else if (req[1]) begin
      gnt_valid = 1'b1;
      gnt_id    = REQ_HOST;
    end
  end

endmodule

`default_nettype wire

// File: rtl/fcb_apbm_arb.sv
// ----------------------------------------------------------------------------
// fcb_apbm_arb : two-requester APB master arbiter with burst lock; access timeout under FCB_ARB_TIMEOUT_EN
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module fcb_apbm_arb
  import fcb_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
`ifdef FCB_ARB_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF
`endif
) (
  input  logic              fcb_clk_i,
  input  logic              fcb_rst_ni,
  input  logic              r0_req_i,
  input  logic              r0_write_i,
  input  logic              r0_lock_i,
  input  logic [ADDR_W-1:0] r0_addr_i,
  input  logic [DATA_W-1:0] r0_wdata_i,
  output logic              r0_done_o,
  output logic              r0_err_o,
  output logic [DATA_W-1:0] r0_rdata_o,
  input  logic              r1_req_i,
  input  logic              r1_write_i,
  input  logic              r1_lock_i,
  input  logic [ADDR_W-1:0] r1_addr_i,
  input  logic [DATA_W-1:0] r1_wdata_i,
  output logic              r1_done_o,
  output logic              r1_err_o,
  output logic [DATA_W-1:0] r1_rdata_o,
  output logic              apb_psel_o,
  output logic              apb_penable_o,
  output logic              apb_pwrite_o,
  output logic [ADDR_W-1:0] apb_paddr_o,
  output logic [DATA_W-1:0] apb_pwdata_o,
  input  logic [DATA_W-1:0] apb_prdata_i,
  input  logic              apb_pready_i,
  input  logic              apb_pslverr_i,
  output logic [1:0]        owner_o
);

  logic [1:0]        state_q, state_d;
  logic              last_q, last_d;
  logic              lock_q, lock_d;
  logic              lock_id_q, lock_id_d;
  logic              id_q, id_d;
  logic              psel_q, psel_d;
  logic              penable_q, penable_d;
  logic              pwrite_q, pwrite_d;
  logic [ADDR_W-1:0] paddr_q, paddr_d;
  logic [DATA_W-1:0] pwdata_q, pwdata_d;
  logic              r0_done_q, r0_done_d;
  logic              r1_done_q, r1_done_d;
  logic              r0_err_q, r0_err_d;
  logic              r1_err_q, r1_err_d;
  logic [DATA_W-1:0] r0_rdata_q, r0_rdata_d;
  logic [DATA_W-1:0] r1_rdata_q, r1_rdata_d;
  logic [1:0]        owner_q, owner_d;

  logic              gnt_valid;
  logic              gnt_id;
  logic              xfer_done;
  logic              xfer_err;
  logic [DATA_W-1:0] xfer_rdata;
  logic              timeout_hit;
  logic              timed_out;

  fcb_arb_rr2 u_rr2 (
    .req       ({r1_req_i, r0_req_i}),
    .last      (last_q),
    .lock      (lock_q),
    .lock_id   (lock_id_q),
    .gnt_valid (gnt_valid),
    .gnt_id    (gnt_id)
  );

`ifdef FCB_ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC) + 1;

  logic [CNT_W-1:0] to_cnt_q, to_cnt_d;
  logic             timed_out_q, timed_out_d;

  always_comb begin
    to_cnt_d = to_cnt_q;
    if (state_q == ST_SETUP) begin
      to_cnt_d = '0;
    end else if ((state_q == ST_ACCESS) && !apb_pready_i) begin
      to_cnt_d = to_cnt_q + CNT_W'(1);
    end
    // pready in the terminal cycle wins, so the abort needs pready low.
    timeout_hit = (state_q == ST_ACCESS) && !apb_pready_i &&
                  (to_cnt_q == CNT_W'(TIMEOUT_CYC - 1));
    timed_out_d = timeout_hit;
  end

  always_ff @(posedge fcb_clk_i or negedge fcb_rst_ni) begin
    if (!fcb_rst_ni) begin
      to_cnt_q    <= '0;
      timed_out_q <= 1'b0;
    end else begin
      to_cnt_q    <= to_cnt_d;
      timed_out_q <= timed_out_d;
    end
  end

  assign timed_out = timed_out_q;
`else
  assign timeout_hit = 1'b0;
  assign timed_out   = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    lock_d     = lock_q;
    lock_id_d  = lock_id_q;
    id_d       = id_q;
    pwrite_d   = pwrite_q;
    paddr_d    = paddr_q;
    pwdata_d   = pwdata_q;
    xfer_done  = 1'b0;
    xfer_err   = 1'b0;
    xfer_rdata = '0;

    case (state_q)
      ST_IDLE: begin
        if (gnt_valid) begin
          id_d     = gnt_id;
          last_d   = gnt_id;
          pwrite_d = (gnt_id == REQ_HOST) ? r1_write_i : r0_write_i;
          paddr_d  = (gnt_id == REQ_HOST) ? r1_addr_i  : r0_addr_i;
          pwdata_d = (gnt_id == REQ_HOST) ? r1_wdata_i : r0_wdata_i;
          state_d  = ST_SETUP;
        end
      end
      ST_SETUP: begin
        state_d = ST_ACCESS;
      end
      ST_ACCESS: begin
        if (apb_pready_i) begin
          xfer_done  = 1'b1;
          xfer_err   = apb_pslverr_i;
          xfer_rdata = pwrite_q ? '0 : apb_prdata_i;
          state_d    = ST_DONE;
        end else if (timeout_hit) begin
          xfer_done = 1'b1;
          xfer_err  = 1'b1;
          state_d   = ST_DONE;
        end
      end
      ST_DONE: begin
        lock_d    = ((id_q == REQ_HOST) ? r1_lock_i : r0_lock_i) & ~timed_out;
        lock_id_d = id_q;
        state_d   = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Outputs are registered, so they are derived from the next state.
    r0_done_d  = xfer_done && (id_q == REQ_JTAG);
    r1_done_d  = xfer_done && (id_q == REQ_HOST);
    r0_err_d   = r0_done_d & xfer_err;
    r1_err_d   = r1_done_d & xfer_err;
    r0_rdata_d = r0_done_d ? xfer_rdata : '0;
    r1_rdata_d = r1_done_d ? xfer_rdata : '0;
    psel_d     = (state_d == ST_SETUP) || (state_d == ST_ACCESS);
    penable_d  = (state_d == ST_ACCESS);

    if (state_d != ST_IDLE) begin
      owner_d = id_onehot(id_d);
    end else if (lock_d) begin
      owner_d = id_onehot(lock_id_d);
    end else begin
      owner_d = 2'b00;
    end
  end

  always_ff @(posedge fcb_clk_i or negedge fcb_rst_ni) begin
    if (!fcb_rst_ni) begin
      state_q    <= ST_IDLE;
      last_q     <= 1'b1;
      lock_q     <= 1'b0;
      lock_id_q  <= REQ_JTAG;
      id_q       <= REQ_JTAG;
      psel_q     <= 1'b0;
      penable_q  <= 1'b0;
      pwrite_q   <= 1'b0;
      paddr_q    <= '0;
      pwdata_q   <= '0;
      r0_done_q  <= 1'b0;
      r1_done_q  <= 1'b0;
      r0_err_q   <= 1'b0;
      r1_err_q   <= 1'b0;
      r0_rdata_q <= '0;
      r1_rdata_q <= '0;
      owner_q    <= 2'b00;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      lock_q     <= lock_d;
      lock_id_q  <= lock_id_d;
      id_q       <= id_d;
      psel_q     <= psel_d;
      penable_q  <= penable_d;
      pwrite_q   <= pwrite_d;
      paddr_q    <= paddr_d;
      pwdata_q   <= pwdata_d;
      r0_done_q  <= r0_done_d;
      r1_done_q  <= r1_done_d;
      r0_err_q   <= r0_err_d;
      r1_err_q   <= r1_err_d;
      r0_rdata_q <= r0_rdata_d;
      r1_rdata_q <= r1_rdata_d;
      owner_q    <= owner_d;
    end
  end

  assign r0_done_o     = r0_done_q;
  assign r1_done_o     = r1_done_q;
  assign r0_err_o      = r0_err_q;
  assign r1_err_o      = r1_err_q;
  assign r0_rdata_o    = r0_rdata_q;
  assign r1_rdata_o    = r1_rdata_q;
  assign apb_psel_o    = psel_q;
  assign apb_penable_o = penable_q;
  assign apb_pwrite_o  = pwrite_q;
  assign apb_paddr_o   = paddr_q;
  assign apb_pwdata_o  = pwdata_q;
  assign owner_o       = owner_q;

endmodule

`default_nettype wire

// File: tb/tb_fcb_apbm_arb.sv
// ----------------------------------------------------------------------------
// tb_fcb_apbm_arb : directed self-checking bench for fcb_apbm_arb
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_fcb_apbm_arb;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        r0_req = 1'b0, r0_write = 1'b0, r0_lock = 1'b0;
  logic [31:0] r0_addr = '0, r0_wdata = '0;
  logic        r1_req = 1'b0, r1_write = 1'b0, r1_lock = 1'b0;
  logic [31:0] r1_addr = '0, r1_wdata = '0;
  logic        r0_done, r0_err, r1_done, r1_err;
  logic [31:0] r0_rdata, r1_rdata;
  logic        psel, penable, pwrite;
  logic [31:0] paddr, pwdata;
  logic [31:0] prdata = '0;
  logic        pready = 1'b1, pslverr = 1'b0;
  logic [1:0]  owner;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  fcb_apbm_arb #(
    .ADDR_W (32),
    .DATA_W (32)
`ifdef FCB_ARB_TIMEOUT_EN
    ,
    .TIMEOUT_CYC (8)
`endif
  ) dut (
    .fcb_clk_i     (clk),
    .fcb_rst_ni    (rst_n),
    .r0_req_i      (r0_req),
    .r0_write_i    (r0_write),
    .r0_lock_i     (r0_lock),
    .r0_addr_i     (r0_addr),
    .r0_wdata_i    (r0_wdata),
    .r0_done_o     (r0_done),
    .r0_err_o      (r0_err),
    .r0_rdata_o    (r0_rdata),
    .r1_req_i      (r1_req),
    .r1_write_i    (r1_write),
    .r1_lock_i     (r1_lock),
    .r1_addr_i     (r1_addr),
    .r1_wdata_i    (r1_wdata),
    .r1_done_o     (r1_done),
    .r1_err_o      (r1_err),
    .r1_rdata_o    (r1_rdata),
    .apb_psel_o    (psel),
    .apb_penable_o (penable),
    .apb_pwrite_o  (pwrite),
    .apb_paddr_o   (paddr),
    .apb_pwdata_o  (pwdata),
    .apb_prdata_i  (prdata),
    .apb_pready_i  (pready),
    .apb_pslverr_i (pslverr),
    .owner_o       (owner)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    n_checks++;
    if ({psel, penable, pwrite, r0_done, r0_err, r1_done, r1_err} !== 7'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b expected 0000000",
               {psel, penable, pwrite, r0_done, r0_err, r1_done, r1_err});
    end
    n_checks++;
    if ({paddr, pwdata, r0_rdata, r1_rdata} !== 128'h0) begin
      n_fail++;
      $display("FAIL reset_data: got %h expected 0", {paddr, pwdata, r0_rdata, r1_rdata});
    end
    n_checks++;
    if (owner !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_owner: got %b expected 00", owner);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single_write();
    r0_req = 1'b1; r0_write = 1'b1; r0_lock = 1'b0;
    r0_addr = 32'h0000_0010; r0_wdata = 32'hA5A5_0001; pready = 1'b1;
    tick();
    n_checks++;
    if ({psel, penable, pwrite, owner} !== 5'b10101 || paddr !== 32'h10 || pwdata !== 32'hA5A5_0001) begin
      n_fail++;
      $display("FAIL single_setup: got sel/en/wr/own=%b addr=%h wdata=%h expected 10101 00000010 a5a50001",
               {psel, penable, pwrite, owner}, paddr, pwdata);
    end
    tick();
    n_checks++;
    if ({psel, penable, r0_done} !== 3'b110) begin
      n_fail++;
      $display("FAIL single_access: got sel/en/done=%b expected 110", {psel, penable, r0_done});
    end
    tick();
    n_checks++;
    if ({r0_done, r0_err, psel, penable} !== 4'b1000 || r0_rdata !== 32'h0) begin
      n_fail++;
      $display("FAIL single_done: got done/err/sel/en=%b rdata=%h expected 1000 0",
               {r0_done, r0_err, psel, penable}, r0_rdata);
    end
    n_checks++;
    if ({r1_done, r1_err} !== 2'b00 || r1_rdata !== 32'h0) begin
      n_fail++;
      $display("FAIL single_r1_quiet: got done/err=%b rdata=%h expected 00 0", {r1_done, r1_err}, r1_rdata);
    end
    r0_req = 1'b0;
    tick();
    n_checks++;
    if ({r0_done, owner} !== 3'b000) begin
      n_fail++;
      $display("FAIL single_after: got done/owner=%b expected 000", {r0_done, owner});
    end
    tick();
  endtask

  task automatic test_rr_tie();
    logic [31:0] pat;
    logic        win;
    do_reset();
    r0_req = 1'b1; r0_write = 1'b0; r0_lock = 1'b0; r0_addr = 32'h100;
    r1_req = 1'b1; r1_write = 1'b0; r1_lock = 1'b0; r1_addr = 32'h200;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) tick();
      pat = 32'h1111_1111 * (k + 1);
      prdata = pat;
      win = k[0];
      tick();
      tick();
      tick();
      n_checks++;
      if ({r0_done, r1_done} !== (win ? 2'b01 : 2'b10)) begin
        n_fail++;
        $display("FAIL rr_order_%0d: got r0/r1 done=%b expected %b", k, {r0_done, r1_done},
                 win ? 2'b01 : 2'b10);
      end
      n_checks++;
      if ((win ? r1_rdata : r0_rdata) !== pat || (win ? r0_rdata : r1_rdata) !== 32'h0 ||
          paddr !== (win ? 32'h200 : 32'h100)) begin
        n_fail++;
        $display("FAIL rr_data_%0d: got win_rdata=%h lose_rdata=%h addr=%h expected %h 0 %h", k,
                 win ? r1_rdata : r0_rdata, win ? r0_rdata : r1_rdata, paddr, pat,
                 win ? 32'h200 : 32'h100);
      end
    end
    r0_req = 1'b0; r1_req = 1'b0;
    repeat (2) tick();
  endtask

  task automatic test_lock_burst();
    r0_req = 1'b1; r0_write = 1'b1; r0_lock = 1'b1; r0_addr = 32'h20; r0_wdata = 32'hB000_0000;
    r1_req = 1'b1; r1_write = 1'b0; r1_lock = 1'b0; r1_addr = 32'h300;
    prdata = 32'h3333_3333;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) begin
        tick();
        n_checks++;
        if ({owner, psel} !== 3'b010) begin
          n_fail++;
          $display("FAIL lock_idle_%0d: got owner/sel=%b expected 010", i, {owner, psel});
        end
        r0_addr = 32'h20 + 32'(4 * i); r0_wdata = 32'hB000_0000 + 32'(i); r0_lock = (i < 3);
      end
      tick();
      n_checks++;
      if ({owner, psel, pwrite} !== 4'b0111 || paddr !== 32'h20 + 32'(4 * i)) begin
        n_fail++;
        $display("FAIL lock_setup_%0d: got owner/sel/wr=%b addr=%h expected 0111 %h", i,
                 {owner, psel, pwrite}, paddr, 32'h20 + 32'(4 * i));
      end
      tick();
      tick();
      n_checks++;
      if ({r0_done, r0_err, r1_done, owner} !== 5'b10001) begin
        n_fail++;
        $display("FAIL lock_done_%0d: got r0done/r0err/r1done/owner=%b expected 10001", i,
                 {r0_done, r0_err, r1_done, owner});
      end
    end
    tick();
    r0_req = 1'b0; r0_lock = 1'b0;
    n_checks++;
    if (owner !== 2'b00) begin
      n_fail++;
      $display("FAIL lock_release: got owner=%b expected 00", owner);
    end
    tick();
    n_checks++;
    if (owner !== 2'b10 || paddr !== 32'h300) begin
      n_fail++;
      $display("FAIL lock_r1_grant: got owner=%b addr=%h expected 10 300", owner, paddr);
    end
    tick();
    tick();
    n_checks++;
    if ({r1_done, r0_done} !== 2'b10 || r1_rdata !== 32'h3333_3333) begin
      n_fail++;
      $display("FAIL lock_r1_done: got r1/r0 done=%b rdata=%h expected 10 33333333",
               {r1_done, r0_done}, r1_rdata);
    end
    r1_req = 1'b0;
    repeat (2) tick();
  endtask

  task automatic test_wait_err();
    r1_req = 1'b1; r1_write = 1'b0; r1_lock = 1'b0; r1_addr = 32'h400;
    pready = 1'b0; pslverr = 1'b0; prdata = 32'h0;
    tick();
    tick();
    for (int w = 0; w < 5; w++) begin
      n_checks++;
      if ({psel, penable, pwrite, r1_done} !== 4'b1100 || paddr !== 32'h400) begin
        n_fail++;
        $display("FAIL wait_stable_%0d: got sel/en/wr/done=%b addr=%h expected 1100 400", w,
                 {psel, penable, pwrite, r1_done}, paddr);
      end
      r1_addr = 32'hFFF0 + 32'(w);
      tick();
    end
    pready = 1'b1; pslverr = 1'b1; prdata = 32'hDEAD_BEEF;
    tick();
    n_checks++;
    if ({r1_done, r1_err, r0_done, psel} !== 4'b1100 || r1_rdata !== 32'hDEAD_BEEF) begin
      n_fail++;
      $display("FAIL wait_err_done: got r1done/r1err/r0done/sel=%b rdata=%h expected 1100 deadbeef",
               {r1_done, r1_err, r0_done, psel}, r1_rdata);
    end
    r1_req = 1'b0; pslverr = 1'b0;
    repeat (2) tick();
  endtask

  task automatic test_lock_hold_reset();
    r1_req = 1'b1; r1_write = 1'b1; r1_lock = 1'b1; r1_addr = 32'h500; r1_wdata = 32'h5555_AAAA;
    pready = 1'b1;
    tick();
    tick();
    tick();
    n_checks++;
    if (r1_done !== 1'b1) begin
      n_fail++;
      $display("FAIL hold_first_done: got r1_done=%b expected 1", r1_done);
    end
    tick();
    r1_req = 1'b0;
    r0_req = 1'b1; r0_write = 1'b0; r0_lock = 1'b0; r0_addr = 32'h600;
    for (int c = 0; c < 4; c++) begin
      tick();
      n_checks++;
      if ({psel, owner} !== 3'b010) begin
        n_fail++;
        $display("FAIL hold_idle_%0d: got sel/owner=%b expected 010", c, {psel, owner});
      end
    end
    r1_req = 1'b1; r1_write = 1'b0; r1_addr = 32'h504; pready = 1'b0;
    tick();
    n_checks++;
    if (owner !== 2'b10 || paddr !== 32'h504) begin
      n_fail++;
      $display("FAIL hold_regrant: got owner=%b addr=%h expected 10 504", owner, paddr);
    end
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({psel, penable, owner} !== 4'b0000) begin
      n_fail++;
      $display("FAIL async_reset: got sel/en/owner=%b expected 0000", {psel, penable, owner});
    end
    tick();
    n_checks++;
    if ({r0_done, r1_done} !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_no_done: got r0/r1 done=%b expected 00", {r0_done, r1_done});
    end
    r1_lock = 1'b0; pready = 1'b1; prdata = 32'h6666_6666;
    rst_n = 1'b1;
    tick();
    n_checks++;
    if (owner !== 2'b01 || paddr !== 32'h600) begin
      n_fail++;
      $display("FAIL post_reset_tie: got owner=%b addr=%h expected 01 600", owner, paddr);
    end
    tick();
    tick();
    n_checks++;
    if ({r0_done, r1_done} !== 2'b10 || r0_rdata !== 32'h6666_6666) begin
      n_fail++;
      $display("FAIL post_reset_done: got r0/r1 done=%b rdata=%h expected 10 66666666",
               {r0_done, r1_done}, r0_rdata);
    end
    r0_req = 1'b0; r1_req = 1'b0;
    repeat (2) tick();
  endtask

  task automatic test_timeout();
    r0_req = 1'b1; r0_write = 1'b0; r0_lock = 1'b1; r0_addr = 32'h700;
    pready = 1'b0; prdata = 32'hCAFE_F00D;
    tick();
    tick();
`ifdef FCB_ARB_TIMEOUT_EN
    for (int c = 0; c < 8; c++) begin
      n_checks++;
      if ({psel, penable, r0_done} !== 3'b110) begin
        n_fail++;
        $display("FAIL timeout_wait_%0d: got sel/en/done=%b expected 110", c, {psel, penable, r0_done});
      end
      tick();
    end
    n_checks++;
    if ({r0_done, r0_err} !== 2'b11 || r0_rdata !== 32'h0) begin
      n_fail++;
      $display("FAIL timeout_done: got done/err=%b rdata=%h expected 11 0", {r0_done, r0_err}, r0_rdata);
    end
    r0_req = 1'b0;
    tick();
    n_checks++;
    if (owner !== 2'b00) begin
      n_fail++;
      $display("FAIL timeout_lock_clear: got owner=%b expected 00", owner);
    end
    r0_lock = 1'b0; pready = 1'b1;
    tick();
`else
    begin
      int seen;
      seen = 0;
      for (int c = 0; c < 1000; c++) begin
        tick();
        if (r0_done || r1_done) seen++;
      end
      n_checks++;
      if (seen != 0 || {psel, penable} !== 2'b11) begin
        n_fail++;
        $display("FAIL no_timeout: got dones=%0d sel/en=%b expected 0 11", seen, {psel, penable});
      end
      r0_req = 1'b0; r0_lock = 1'b0; pready = 1'b1;
      do_reset();
      tick();
    end
`endif
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_single_write();
    test_rr_tie();
    test_lock_burst();
    test_wait_err();
    test_lock_hold_reset();
    test_timeout();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/fcb_apbm_arb.md
Name: fcb_apbm_arb

Overview:
- Two-requester APB master arbiter that shares the FCB APB slave port between the JTAG bridge (requester 0) and the SoC host bridge (requester 1).
- Each requester issues single transfers over a simple req/done handshake. The arbiter picks a winner, runs one APB SETUP/ACCESS transfer on the FCB APB slave port, and returns read data and error to that requester.
- A per-requester lock keeps ownership across a configuration burst, so bitstream writes from one source are never interleaved with the other.

Parameters:
- ADDR_W, 32, APB address width.
- DATA_W, 32, APB data width.
- TIMEOUT_CYC, 256, ACCESS-phase cycles before abort. Used only with FCB_ARB_TIMEOUT_EN.

Ports:
- fcb_clk_i  in  1  clock.
- fcb_rst_ni  in  1  reset, asynchronous, active-low.
- r0_req_i / r1_req_i  in  1  transfer request; held high until done.
- r0_write_i / r1_write_i  in  1  1 = write, 0 = read.
- r0_lock_i / r1_lock_i  in  1  keep grant after the current transfer.
- r0_addr_i / r1_addr_i  in  ADDR_W  address.
- r0_wdata_i / r1_wdata_i  in  DATA_W  write data.
- r0_done_o / r1_done_o  out  1  one-cycle completion pulse.
- r0_err_o / r1_err_o  out  1  valid with done; pslverr or timeout.
- r0_rdata_o / r1_rdata_o  out  DATA_W  valid with done.
- apb_psel_o, apb_penable_o, apb_pwrite_o  out  1  APB master controls.
- apb_paddr_o  out  ADDR_W  APB address.
- apb_pwdata_o  out  DATA_W  APB write data.
- apb_prdata_i  in  DATA_W  APB read data.
- apb_pready_i, apb_pslverr_i  in  1  APB response.
- owner_o  out  2  bit n = requester n granted (SETUP..DONE) or locked.

Behaviour:
- All outputs are registered. Reset value of every output is 0.
- Internal reset state: state = IDLE, last_q = 1 (so r0 wins the first tie), lock_q = 0, lock_id_q = 0.
- FSM states: IDLE, SETUP, ACCESS, DONE.
- IDLE:
  - If lock_q = 1, only requester lock_id_q is eligible.
  - Otherwise, a single request wins outright. If both request, the winner is !last_q (round-robin).
  - On a grant: latch the winner's id, write, addr and wdata; set last_q = id; go to SETUP.
- SETUP: psel = 1, penable = 0, latched fields on the APB bus. Always goes to ACCESS next cycle.
- ACCESS:
  - psel = 1, penable = 1.
  - Waits on pready.
  - When pready = 1: capture prdata (reads only; write returns 0) and pslverr, then go to DONE.
- DONE:
  - psel = 0 and penable = 0.
  - Owner's done_o = 1 for exactly this cycle, with rdata_o and err_o valid. The other requester's done/err/rdata stay 0.
  - lock_q is loaded from the owner's lock_i; lock_id_q is loaded with the owner id.
  - Next state is IDLE.
- Requester rule: deassert req, or present the next transfer, on the edge after done. req is never sampled during DONE, so the same request cannot be re-issued.
- Minimum latency, req to done: 3 cycles (IDLE, SETUP, ACCESS with pready = 1). Done appears in cycle 3; the next grant is possible in cycle 4.
- APB bus stability: paddr, pwrite and pwdata are held stable from SETUP through ACCESS. They keep their last values in IDLE/DONE, since psel is low.
- Lock release: lock is released when the locked owner is in DONE with lock_i = 0. While locked, the other requester waits indefinitely.
- Lock with no pending request: if the locked owner has no request in IDLE, the FSM stays in IDLE and the lock is held.
- Request changes: changes on a requester's inputs after grant are ignored until the next IDLE.
- Reset mid-transfer: psel and penable drop immediately (asynchronous). No done is emitted and the lock clears.

Optional Feature:
- Macro: FCB_ARB_TIMEOUT_EN.
- Defined:
  - A cycle counter (width $clog2(TIMEOUT_CYC)+1) clears on entry to ACCESS and increments each ACCESS cycle without pready.
  - When it reaches TIMEOUT_CYC - 1 with pready = 0, the FSM goes to DONE with err = 1 and rdata = 0.
  - A timeout also forces lock_q = 0.
  - A pready arriving in the same cycle as the timeout takes precedence (normal completion).
- Undefined: there is no counter, and ACCESS waits for pready forever.

Decomposition:
- Package/include fcb_arb_pkg:
  - State encoding (IDLE = 2'd0, SETUP = 2'd1, ACCESS = 2'd2, DONE = 2'd3).
  - Requester ids REQ_JTAG = 1'b0, REQ_HOST = 1'b1.
  - Default TIMEOUT_CYC.
- Sub-module fcb_arb_rr2: combinational 2-way round-robin pick with lock qualifier.
  - Inputs: req[1:0], last, lock, lock_id.
  - Outputs: gnt_valid, gnt_id.

Test Plan:
- Single r0 write: addr 0x0000_0010, wdata 0xA5A5_0001, pready held 1.
  - psel in cycles 1-2, penable in cycle 2; r0_done in cycle 3 with err 0.
  - r1 outputs stay 0.
- Both requesters read in the same cycle after reset, pready 1, both keep re-requesting.
  - Grant order r0, r1, r0, r1. Each done carries the prdata driven in that transfer (0x1111_1111, 0x2222_2222, ...).
- r0 lock burst: r0 issues 4 writes with lock = 1 on the first 3 and lock = 0 on the 4th; r1 requests throughout.
  - All 4 r0 transfers complete back-to-back; r1 is granted only after the 4th done.
  - owner_o = 2'b01 throughout the burst.
- Wait states and error: r1 read, pready low for 5 ACCESS cycles, then pready = 1 with pslverr = 1.
  - r1_done one cycle later with r1_err = 1; APB signals stable during all wait cycles.
- Reset during ACCESS: assert fcb_rst_ni low with pready = 0.
  - psel and penable go low immediately; no done pulse; owner_o = 0.
  - The first transfer after reset is granted to r0 on a tie.
- FCB_ARB_TIMEOUT_EN with TIMEOUT_CYC = 8 and pready held 0:
  - err done after 8 ACCESS cycles, rdata 0, lock cleared.
  - With the macro undefined, no done after 1000 cycles.
